// File: rtl/mac_bist_controller.sv
// mac_bist_controller
//   Built-in self-test sequencer for the MAC processing element. It walks every
//   test-pattern ROM address and registers the a/w/p operands into the MAC.
//   It then waits out the MAC pipeline latency and compares the MAC result
//   against the ROM golden value. It reports pass/fail, a mismatch count and the
//   first failing address.
//
//   Optional feature macro: BIST_STOP_ON_FAIL_EN
//     When defined, the first mismatch ends the run immediately.
//     When undefined (the default), every pattern runs and every mismatch is counted.
//
// Ports
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   start                      one-cycle pulse; ignored while busy
//   rom_addr                   address to the combinational pattern ROM
//   rom_tp_a/w/p, rom_expected_p   ROM operands and golden result
//   mac_a/w/p, mac_valid       registered operands to the MAC, new-operand strobe
//   mac_result                 MAC output
//   busy, done, pass           run status (done is a level until the next start)
//   fail_count, first_fail_addr    result summary
module mac_bist_controller #(
  parameter int unsigned NUM_PATTERNS = 16,
  parameter int unsigned ADDR_WIDTH   = $clog2(NUM_PATTERNS),
  parameter int unsigned A_WIDTH      = 8,
  parameter int unsigned W_WIDTH      = 8,
  parameter int unsigned P_WIDTH      = 32,
  parameter int unsigned MAC_LATENCY  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [A_WIDTH-1:0]    rom_tp_a,
  input  logic [W_WIDTH-1:0]    rom_tp_w,
  input  logic [P_WIDTH-1:0]    rom_tp_p,
  input  logic [P_WIDTH-1:0]    rom_expected_p,
  output logic [A_WIDTH-1:0]    mac_a,
  output logic [W_WIDTH-1:0]    mac_w,
  output logic [P_WIDTH-1:0]    mac_p,
  output logic                  mac_valid,
  input  logic [P_WIDTH-1:0]    mac_result,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH:0]   fail_count,
  output logic [ADDR_WIDTH-1:0] first_fail_addr
);

  localparam int unsigned CntW = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(NUM_PATTERNS - 1);
  localparam logic [CntW-1:0] WaitInit = CntW'(MAC_LATENCY - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWait,
    StCompare,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   fail_cnt_q, fail_cnt_d;
  logic [ADDR_WIDTH-1:0] first_fail_q, first_fail_d;
  logic                  fail_seen_q, fail_seen_d;
  logic [A_WIDTH-1:0]    mac_a_q, mac_a_d;
  logic [W_WIDTH-1:0]    mac_w_q, mac_w_d;
  logic [P_WIDTH-1:0]    mac_p_q, mac_p_d;
  logic [P_WIDTH-1:0]    exp_q, exp_d;
  logic                  mac_valid_q, mac_valid_d;
  logic [CntW-1:0]       wait_cnt_q, wait_cnt_d;

  logic mismatch;
  logic run_end;

  assign mismatch = (mac_result != exp_q);

`ifdef BIST_STOP_ON_FAIL_EN
  assign run_end = mismatch || (addr_q == LastAddr);
`else
  assign run_end = (addr_q == LastAddr);
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    fail_cnt_d   = fail_cnt_q;
    first_fail_d = first_fail_q;
    fail_seen_d  = fail_seen_q;
    mac_a_d      = mac_a_q;
    mac_w_d      = mac_w_q;
    mac_p_d      = mac_p_q;
    exp_d        = exp_q;
    wait_cnt_d   = wait_cnt_q;
    // The strobe marks the first cycle in which the new operands are visible.
    mac_valid_d  = (state_q == StLoad);

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d      = StLoad;
          addr_d       = '0;
          fail_cnt_d   = '0;
          first_fail_d = '0;
          fail_seen_d  = 1'b0;
        end
      end
      StLoad: begin
        mac_a_d    = rom_tp_a;
        mac_w_d    = rom_tp_w;
        mac_p_d    = rom_tp_p;
        exp_d      = rom_expected_p;
        wait_cnt_d = WaitInit;
        state_d    = StWait;
      end
      StWait: begin
        if (wait_cnt_q == '0) begin
          state_d = StCompare;
        end else begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end
      end
      StCompare: begin
        if (mismatch) begin
          fail_cnt_d = fail_cnt_q + 1'b1;
          if (!fail_seen_q) begin
            first_fail_d = addr_q;
            fail_seen_d  = 1'b1;
          end
        end
        if (run_end) begin
          state_d = StDone;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = StLoad;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      fail_cnt_q   <= '0;
      first_fail_q <= '0;
      fail_seen_q  <= 1'b0;
      mac_a_q      <= '0;
      mac_w_q      <= '0;
      mac_p_q      <= '0;
      exp_q        <= '0;
      mac_valid_q  <= 1'b0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      fail_cnt_q   <= fail_cnt_d;
      first_fail_q <= first_fail_d;
      fail_seen_q  <= fail_seen_d;
      mac_a_q      <= mac_a_d;
      mac_w_q      <= mac_w_d;
      mac_p_q      <= mac_p_d;
      exp_q        <= exp_d;
      mac_valid_q  <= mac_valid_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  assign rom_addr        = addr_q;
  assign mac_a           = mac_a_q;
  assign mac_w           = mac_w_q;
  assign mac_p           = mac_p_q;
  assign mac_valid       = mac_valid_q;
  assign busy            = (state_q == StLoad) || (state_q == StWait) || (state_q == StCompare);
  assign done            = (state_q == StDone);
  assign pass            = done && (fail_cnt_q == '0);
  assign fail_count      = fail_cnt_q;
  assign first_fail_addr = first_fail_q;

endmodule

// File: tb/tb_mac_bist_controller.sv
// Testbench for mac_bist_controller: pattern ROM and latency-2 MAC models with
// injectable faults, randomized ROM contents, and a reference model that
// derives the expected run outcome directly from the ROM arrays.
module tb_mac_bist_controller;

  localparam int NumPat = 16;
  localparam int MacLat = 2;
  localparam int PatCyc = MacLat + 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [3:0]         rom_addr;
  logic signed [7:0]  rom_tp_a, rom_tp_w;
  logic signed [31:0] rom_tp_p, rom_expected_p;
  logic signed [7:0]  mac_a, mac_w;
  logic signed [31:0] mac_p;
  logic               mac_valid;
  logic signed [31:0] mac_result;
  logic               busy, done, pass;
  logic [4:0]         fail_count;
  logic [3:0]         first_fail_addr;

  logic signed [7:0]  rom_a [NumPat];
  logic signed [7:0]  rom_w [NumPat];
  logic signed [31:0] rom_p [NumPat];
  logic signed [31:0] rom_e [NumPat];

  // 0 none, 1 +1 on addresses in fault_map, 2 bit0 stuck-at-0, 3 bit31 stuck-at-1
  int          fault_kind = 0;
  logic [15:0] fault_map = '0;

  int n_checks = 0;
  int n_fail = 0;

  mac_bist_controller #(
    .NUM_PATTERNS(NumPat),
    .MAC_LATENCY (MacLat)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .rom_addr       (rom_addr),
    .rom_tp_a       (rom_tp_a),
    .rom_tp_w       (rom_tp_w),
    .rom_tp_p       (rom_tp_p),
    .rom_expected_p (rom_expected_p),
    .mac_a          (mac_a),
    .mac_w          (mac_w),
    .mac_p          (mac_p),
    .mac_valid      (mac_valid),
    .mac_result     (mac_result),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .fail_count     (fail_count),
    .first_fail_addr(first_fail_addr)
  );

  always #5 clk = ~clk;

  assign rom_tp_a       = rom_a[rom_addr];
  assign rom_tp_w       = rom_w[rom_addr];
  assign rom_tp_p       = rom_p[rom_addr];
  assign rom_expected_p = rom_e[rom_addr];

  function automatic int apply_fault(input int v, input int addr, input int kind,
                                     input logic [15:0] map);
    case (kind)
      1: return map[addr] ? v + 1 : v;
      2: return v & ~32'sd1;
      3: return v | 32'h8000_0000;
      default: return v;
    endcase
  endfunction

  // MAC under test: MacLat-stage pipeline, tagged with the address being tested.
  logic signed [31:0] pipe_q [MacLat];
  logic [3:0]         tag_q  [MacLat];
  always @(posedge clk) begin
    pipe_q[0] <= 32'(mac_a) * 32'(mac_w) + mac_p;
    tag_q[0]  <= rom_addr;
    for (int i = 1; i < MacLat; i++) begin
      pipe_q[i] <= pipe_q[i-1];
      tag_q[i]  <= tag_q[i-1];
    end
  end
  always_comb mac_result = apply_fault(pipe_q[MacLat-1], int'(tag_q[MacLat-1]), fault_kind,
                                       fault_map);

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Expected outcome from the ROM arrays and the active fault.
  task automatic model(output int fails, output int first, output int len, output int npat);
    int cnt = 0;
    int ff = -1;
    for (int i = 0; i < NumPat; i++) begin
      int golden = int'(rom_a[i]) * int'(rom_w[i]) + int'(rom_p[i]);
      int obs = apply_fault(golden, i, fault_kind, fault_map);
      if (obs != int'(rom_e[i])) begin
        cnt++;
        if (ff < 0) ff = i;
      end
    end
    first = (ff < 0) ? 0 : ff;
`ifdef BIST_STOP_ON_FAIL_EN
    fails = (cnt > 0) ? 1 : 0;
    npat  = (cnt > 0) ? ff + 1 : NumPat;
`else
    fails = cnt;
    npat  = NumPat;
`endif
    len = npat * PatCyc;
  endtask

  task automatic load_default_rom();
    for (int i = 0; i < NumPat; i++) begin
      rom_a[i] = '0; rom_w[i] = '0; rom_p[i] = '0; rom_e[i] = '0;
    end
    rom_a[1] = 10;  rom_w[1] = 15; rom_e[1] = 150;
    rom_a[2] = 5;   rom_w[2] = 10; rom_e[2] = 50;
    rom_a[3] = 10;  rom_w[3] = 10; rom_p[3] = 50;  rom_e[3] = 150;
    rom_a[4] = -10; rom_w[4] = 15; rom_e[4] = -150;
    rom_a[5] = -5;  rom_w[5] = 10; rom_e[5] = -50;
  endtask

  task automatic load_random_rom();
    for (int i = 0; i < NumPat; i++) begin
      rom_a[i] = 8'($urandom);
      rom_w[i] = 8'($urandom);
      rom_p[i] = 32'($urandom);
      rom_e[i] = 32'(int'(rom_a[i]) * int'(rom_w[i]) + int'(rom_p[i]));
      if ($urandom_range(0, 7) == 0) rom_e[i] = rom_e[i] ^ (32'sd1 << $urandom_range(0, 31));
    end
  endtask

  // One full run; mid_n > 0 re-pulses start at that cycle of the run.
  task automatic run_bist(input string name, input int mid_n);
    int fails, first, len, npat;
    int n, valids, last_v, space_err;
    bit got_done;
    model(fails, first, len, npat);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 1;  // now in the LOAD cycle
    check_eq({name, " busy@load"}, busy, 1);
    check_eq({name, " done@load"}, done, 0);
    check_eq({name, " cnt_clr@load"}, fail_count, 0);
    valids = 0; last_v = 0; space_err = 0; got_done = 0;
    while (!got_done && n < 400) begin
      @(posedge clk);
      #1;
      n++;
      start = (n == mid_n);
      if (mac_valid) begin
        if (valids == 0 ? (n != 2) : (n - last_v != PatCyc)) space_err++;
        valids++;
        last_v = n;
      end
      got_done = done;
    end
    start = 1'b0;
    check_eq({name, " reached_done"}, got_done, 1);
    check_eq({name, " run_len"}, n - 1, len);
    check_eq({name, " valid_pulses"}, valids, npat);
    check_eq({name, " valid_spacing_errs"}, space_err, 0);
    check_eq({name, " fail_count"}, fail_count, fails);
    check_eq({name, " first_fail_addr"}, first_fail_addr, first);
    check_eq({name, " pass"}, pass, fails == 0);
    check_eq({name, " busy@done"}, busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check_eq({name, " done_held"}, done, 1);
    check_eq({name, " count_held"}, fail_count, fails);
  endtask

  task automatic check_outputs_zero(input string name);
    check_eq({name, " rom_addr"}, rom_addr, 0);
    check_eq({name, " mac_a"}, mac_a, 0);
    check_eq({name, " mac_w"}, mac_w, 0);
    check_eq({name, " mac_p"}, mac_p, 0);
    check_eq({name, " mac_valid"}, mac_valid, 0);
    check_eq({name, " busy"}, busy, 0);
    check_eq({name, " done"}, done, 0);
    check_eq({name, " pass"}, pass, 0);
    check_eq({name, " fail_count"}, fail_count, 0);
    check_eq({name, " first_fail_addr"}, first_fail_addr, 0);
  endtask

  initial begin
    int guard;
    load_default_rom();
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("idle busy", busy, 0);

    fault_kind = 0;
    run_bist("golden", 0);
    fault_kind = 1; fault_map = 16'h0008;
    run_bist("fault_at3", 0);
    fault_kind = 2;
    run_bist("stuck_b0", 0);
    fault_kind = 3;
    run_bist("stuck_b31", 0);
    fault_kind = 0;
    run_bist("rerun_golden", 0);
    fault_kind = 1; fault_map = 16'h0104;
    run_bist("busy_protect", 20);

    // Reset in the middle of pattern 7 with a failure already recorded.
    fault_kind = 1; fault_map = 16'h0004;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    guard = 0;
    while (rom_addr != 4'd7 && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check_eq("mid reach addr7", rom_addr, 7);
    check_eq("mid pre_reset fails", fail_count, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_eq("post_reset busy", busy, 0);
    check_eq("post_reset done", done, 0);
    check_eq("post_reset rom_addr", rom_addr, 0);
    run_bist("after_reset", 0);

    for (int r = 0; r < 6; r++) begin
      load_random_rom();
      fault_kind = $urandom_range(0, 3);
      fault_map  = 16'($urandom) & 16'($urandom);
      run_bist($sformatf("rand%0d", r), (r % 2 == 1) ? int'($urandom_range(3, 40)) : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got timeout, expected finish");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/mac_bist_controller.md
# mac_bist_controller

- Built-in self-test sequencer for the MAC processing element.
- Walks every address of the test-pattern ROM and registers the ROM's `a`/`w`/`p` operands into the MAC under test.
- Waits the MAC's fixed pipeline latency, then compares the MAC result against the ROM's `expected_p`.
- Reports pass/fail status, a fail count and the first failing address. Sits between the ROM and the MAC; started by the top-level test-mode logic.

## Interface

Parameters:
- `NUM_PATTERNS`, 16, number of ROM entries tested (addresses 0..NUM_PATTERNS-1).
- `ADDR_WIDTH`, `$clog2(NUM_PATTERNS)`, ROM address width.
- `A_WIDTH`, 8, activation operand width (signed).
- `W_WIDTH`, 8, weight operand width (signed).
- `P_WIDTH`, 32, partial-sum / result width (signed).
- `MAC_LATENCY`, 2, cycles from operands stable at the MAC input to a valid `mac_result`; must be ≥1.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle pulse that begins a test run.
- `rom_addr`, out, ADDR_WIDTH: address to the ROM (combinational ROM).
- `rom_tp_a` / `rom_tp_w` / `rom_tp_p`, in, A_WIDTH / W_WIDTH / P_WIDTH: ROM operands.
- `rom_expected_p`, in, P_WIDTH: ROM golden result.
- `mac_a` / `mac_w` / `mac_p`, out, A_WIDTH / W_WIDTH / P_WIDTH: registered operands to the MAC.
- `mac_valid`, out, 1: high for one cycle when new operands first appear.
- `mac_result`, in, P_WIDTH: MAC output.
- `busy`, out, 1: run in progress.
- `done`, out, 1: run finished. Level; held until the next accepted `start`.
- `pass`, out, 1: `done` && `fail_count == 0`.
- `fail_count`, out, ADDR_WIDTH+1: number of mismatching patterns.
- `first_fail_addr`, out, ADDR_WIDTH: address of the first mismatch; 0 if none.

## Operation

FSM states: IDLE, LOAD, WAIT, COMPARE, DONE.

- **IDLE**
  - `start` → LOAD.
  - On entry to LOAD from IDLE or DONE: clear `rom_addr`, `fail_count`, `first_fail_addr`, the fail-seen flag and `done`.
- **LOAD** (1 cycle)
  - Register `rom_tp_a/w/p` into `mac_a/w/p`.
  - Register `rom_expected_p` into an internal `exp_q`.
  - Set `mac_valid` for the next cycle → WAIT with wait counter = MAC_LATENCY-1.
- **WAIT** (MAC_LATENCY cycles)
  - `mac_*` held stable.
  - Counter decrements; at 0 → COMPARE.
- **COMPARE** (1 cycle)
  - Full P_WIDTH bitwise equality `mac_result == exp_q`.
  - On mismatch: increment `fail_count`. If the fail-seen flag is clear, load `first_fail_addr = rom_addr` and set the flag.
  - If `rom_addr == NUM_PATTERNS-1` → DONE; else increment `rom_addr` → LOAD.
- **DONE**
  - `done` = 1, `busy` = 0, results held.
  - `start` → LOAD (re-run, with results cleared).

Rules and boundary conditions:
- `busy` = 1 in LOAD/WAIT/COMPARE.
- `start` while `busy` is ignored.
- `rom_addr` never wraps; the terminal address is NUM_PATTERNS-1.
- `fail_count` cannot overflow: its maximum is NUM_PATTERNS, which fits in ADDR_WIDTH+1 bits.
- Address 0 (all-zero default entry) is tested like any other.

## Timing

- Reset (async assert, sync to `clk` on deassert): state = IDLE; all outputs 0.
- `start` sampled high at edge k → LOAD during cycle k+1.
- Operands visible from cycle k+2; `mac_valid` high in cycle k+2 only.
- Per pattern: MAC_LATENCY+2 cycles.
- Full run: `done` rises NUM_PATTERNS×(MAC_LATENCY+2) cycles after the LOAD entry. Default: 16×4 = 64.
- `pass`/`fail_count`/`first_fail_addr` are final in the same cycle `done` rises.
- Reset mid-run: immediate return to IDLE; all outputs 0; no partial results retained.

## Configuration

- `BIST_STOP_ON_FAIL_EN` defined:
  - A mismatch in COMPARE goes directly to DONE.
  - `fail_count` = 1, `first_fail_addr` = failing address, `pass` = 0.
  - Remaining patterns are skipped.
- Undefined (default): all NUM_PATTERNS patterns are always run and every mismatch is counted.

## Test plan

- **Golden run:** ideal MAC model (latency 2), `start` pulse → `done` 64 cycles after LOAD entry, `pass` = 1, `fail_count` = 0, `mac_valid` pulsed 16 times at 4-cycle spacing.
- **Single fault:** model adds +1 at address 3 → `pass` = 0, `fail_count` = 1, `first_fail_addr` = 3.
- **Stuck-at fault:** result bit 0 stuck at 0. With default ROM contents (addresses 1..5 results 150, 50, 150, -150, -50, rest 0), no odd results exist → `pass` = 1. Then bit 31 stuck at 1 → `fail_count` = 14 (every non-negative entry), `first_fail_addr` = 0.
- **Busy protection:** `start` re-pulsed mid-run → ignored, run length unchanged. `start` in DONE → counters cleared, new 64-cycle run.
- **Reset mid-run:** `rst_n` low at pattern 7 → all outputs 0 asynchronously. After release, IDLE until `start`.
- **Stop on fail:** with `BIST_STOP_ON_FAIL_EN` and a fault at address 3 → `done` after 4×4 = 16 cycles, `fail_count` = 1, `first_fail_addr` = 3.
